ssd_driver: RTL
===============

# ssd_driver

Four-digit, multiplexed seven-segment display driver for the 13-bit debug value the CPU top level presents on its `ssd_o` output. It converts the binary value to BCD with a sequential double-dabble engine. It then scans the digits onto a common-anode display, with active-low anodes and segments, as used on the board. It sits between the CPU core and the board display pins.

## Interface
- `DIGIT_CYCLES`, default 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz). Minimum is 2.
- `BLANK_LZ`, default 1: when 1, leading zeros are blanked.
- `clk` input 1: rising-edge clock; the block uses this single clock.
- `rst` input 1: reset, asynchronous and active-low.
- `value_i` input 13: binary value to display, range 0–8191.
- `anode_o` output 4: digit enables, active-low. Bit 0 is the rightmost (ones) digit.
- `seg_o` output 7: segments, active-low, order {g,f,e,d,c,b,a}, so bit 0 is segment a.
- `busy_o` output 1: high while a conversion is in progress (states SHIFT and LOAD).

## Operation
- The converter FSM has three states: IDLE, SHIFT and LOAD.
- **IDLE:** a conversion starts if `value_i != last_val` or `first` = 1.
  - Capture `value_i` into a 13-bit binary shift register.
  - Clear the 16-bit BCD register and the bit counter.
  - Clear `first`, set `last_val` to the captured value, and go to SHIFT.
- **SHIFT:** one shift per cycle.
  - First, add 3 to each BCD nibble that is ≥5.
  - Then shift {bcd, bin} left by one bit.
  - After the 13th shift, go to LOAD.
- **LOAD:** copy the BCD register to `disp_bcd` (16 bits) in one cycle, so the update is atomic, then go to IDLE.
- **Input changes during a conversion:** changes to `value_i` in SHIFT or LOAD are ignored. The current conversion completes, and the new value is picked up on the next IDLE cycle. Intermediate values are never shown.
- **Result range:** the thousands digit is ≤8 and every nibble is ≤9. A digit code of 10–15 is unreachable; if it occurs, drive segments all-off (7'h7F).
- **Scan counter:**
  - `cnt` counts 0..DIGIT_CYCLES-1.
  - At terminal count, `cnt` wraps to 0 and `idx` increments modulo 4 (3→0).
- **Output registers:** every cycle, register `anode_o = ~(1<<idx)` and `seg_o = enc(disp_bcd[idx])`.
- **Leading-zero blanking (BLANK_LZ = 1):**
  - Digit k > 0 is blanked if it and all higher digits are 0.
  - A blanked digit drives `seg_o = 7'h7F`; its anode is still asserted.
  - Digit 0 is never blanked.
- **Segment codes (gfedcba, active-low):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

## Timing
- **Reset values (asserted asynchronously):**
  - `anode_o` = 4'b1111, `seg_o` = 7'h7F, `busy_o` = 0.
  - State = IDLE, `first` = 1, `disp_bcd` = 0, `last_val` = 0, `cnt` = 0, `idx` = 0.
- **Reset release:**
  - The first edge registers `anode_o` = 4'b1110 and `seg_o` = 1000000 ("0").
  - The same edge starts a conversion, because `first` = 1.
- **Conversion latency:**
  - Edge N: capture; `busy_o` rises.
  - Edges N+1..N+13: the 13 shifts.
  - Edge N+14: LOAD writes `disp_bcd`; `busy_o` falls.
  - Edge N+15: the new digit can appear on `seg_o`.
- Back-to-back conversions are 15 cycles apart at minimum.
- `seg_o` and `anode_o` lag `idx` and `disp_bcd` by one register stage.
- Each digit is lit for exactly DIGIT_CYCLES cycles, and the scan never stalls during a conversion.
- Reset in the middle of a conversion aborts it and leaves `disp_bcd` = 0.

## Structure
- **Package `ssd_pkg`:**
  - converter state enum (IDLE/SHIFT/LOAD)
  - `NUM_DIGITS` = 4, `VAL_W` = 13, `BCD_W` = 16
  - `SEG_BLANK` = 7'h7F
  - a function mapping a digit to its segment code
- **Sub-module `bin2bcd_seq`:**
  - contains the FSM, the shift and BCD registers, the bit counter, `last_val` and `first`
  - interface: `clk`, `rst`, `value_i`, `bcd_o[15:0]` (i.e. `disp_bcd`), `busy_o`
- **Top level:** the scan counter, the blanking logic and the output registers.

## Test plan
All scenarios use `DIGIT_CYCLES` = 4 unless stated.
- **Reset:** assert `rst` = 0 mid-run → `anode_o` = 1111, `seg_o` = 7F and `busy_o` = 0 immediately; release → first edge gives `anode_o` = 1110, `seg_o` = 1000000.
- **Normal value:** `value_i` = 1234 → `busy_o` high for 14 cycles and `disp_bcd` = 16'h1234 at edge N+14. One scan frame then shows, in order:
  - digit 0 = 0011001 ("4")
  - digit 1 = 0110000 ("3")
  - digit 2 = 0100100 ("2")
  - digit 3 = 1111001 ("1")
  - each digit lasts 4 cycles and `anode_o` walks 1110→1101→1011→0111→1110.
- **Maximum and zero:**
  - `value_i` = 8191 → `disp_bcd` = 16'h8191.
  - `value_i` = 0 with BLANK_LZ = 1 → digits 1–3 show 7F and digit 0 shows 1000000.
  - With BLANK_LZ = 0 → all four digits show 1000000.
- **Input change mid-conversion:** set `value_i` = 5, then change it to 9 five cycles later → `disp_bcd` becomes 0x0005 at N+14 and 0x0009 15 cycles later. No other intermediate value appears.
- **Reset mid-conversion:** reset at shift 7 of 1234, then release with `value_i` = 42 → `disp_bcd` = 0 until it becomes 0x0042, 14 edges after the first post-release edge. No partial 1234 result is ever loaded.
- **Scan timing:** with `DIGIT_CYCLES` = 100000 (or 7 for a shortened run) → each `anode_o` pattern holds exactly that many cycles, and `idx` wraps from 3 to 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: converter state type, display constants and the digit-to-segment encoder.
// Rev 1.0
`default_nettype none

package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_e;

    localparam int NUM_DIGITS = 4;
    localparam int VAL_W      = 13;
    localparam int BCD_W      = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low common-anode codes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter; publishes a new BCD result atomically.
// Rev 1.0
`default_nettype none

module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             busy_o
);

    conv_state_e      state_q, state_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [VAL_W-1:0] last_val_q, last_val_d;
    logic             first_q, first_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic [BCD_W-1:0] adj;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            last_val_q <= '0;
            first_q    <= 1'b1;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            last_val_q <= last_val_d;
            first_q    <= first_d;
            disp_q     <= disp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        last_val_d = last_val_q;
        first_d    = first_q;
        disp_d     = disp_q;

        adj = bcd_q;
        for (int k = 0; k < BCD_W / 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (first_q || (value_i != last_val_q)) begin
                    bin_d      = value_i;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                    first_d    = 1'b0;
                    last_val_d = value_i;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The adjusted BCD never overflows its top bit for 13-bit inputs.
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                bit_cnt_d      = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(VAL_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bcd_o  = disp_q;
    assign busy_o = (state_q != IDLE);

endmodule

`default_nettype wire

// File: rtl/ssd_driver.sv
// ssd_driver: four-digit multiplexed common-anode seven-segment driver for a 13-bit value.
// Rev 1.0
`default_nettype none

module ssd_driver
    import ssd_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_LZ     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VAL_W-1:0]      value_i,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic [6:0]            seg_o,
    output logic                  busy_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    logic [BCD_W-1:0]      disp_bcd;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            digit;
    logic [NUM_DIGITS:0]   blank;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .bcd_o   (disp_bcd),
        .busy_o  (busy_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // blank[k] means digit k and every digit above it are zero; the top sentinel seeds the chain.
        blank             = '0;
        blank[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            blank[k] = (disp_bcd[4*k +: 4] == 4'd0) && blank[k+1];
        end

        digit   = disp_bcd[{idx_q, 2'b00} +: 4];
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        if ((BLANK_LZ != 0) && blank[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_encode(digit);
        end
    end

    assign anode_o = anode_q;
    assign seg_o   = seg_q;

endmodule

`default_nettype wire
